// File: rtl/wb_regfile_hilo.sv
// wb_regfile_hilo
// Write-back architectural state: 31 writable GPRs plus HI/LO, two
// combinational decode read ports with optional same-cycle WB forwarding,
// and a registered one-cycle-latency commit trace for the compare harness.
module wb_regfile_hilo #(
  parameter int WIDTH  = 32,
  parameter bit BYPASS = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               RegWrite,
  input  logic [6:0]         WritetoRFaddr,
  input  logic [WIDTH-1:0]   WritetoRFdata,
  input  logic               HI_LO_writeenable,
  input  logic [2*WIDTH-1:0] WriteinRF_HI_LO_data,
  input  logic [31:0]        PC,
  input  logic [4:0]         raddr1,
  input  logic [4:0]         raddr2,
  output logic [WIDTH-1:0]   rdata1,
  output logic [WIDTH-1:0]   rdata2,
  output logic [WIDTH-1:0]   hi_out,
  output logic [WIDTH-1:0]   lo_out,
  output logic [31:0]        debug_wb_pc,
  output logic [3:0]         debug_wb_rf_wen,
  output logic [4:0]         debug_wb_rf_wnum,
  output logic [WIDTH-1:0]   debug_wb_rf_wdata
);

  localparam int NUM_GPR   = 32;
  localparam int NUM_PORTS = 2;

  // ------------------------------------------------------------------
  // Write qualification
  // ------------------------------------------------------------------
  // Only destinations in the low 32-entry window are GPRs; the rest of the
  // 7-bit space (CP0 and friends) is handled elsewhere and must not touch
  // this file, its bypass or its trace.
  logic             gpr_space;
  logic             gpr_we;
  logic [4:0]       gpr_idx;
  logic [WIDTH-1:0] hi_in;
  logic [WIDTH-1:0] lo_in;

  assign gpr_space = (WritetoRFaddr[6:5] == 2'b00);
  assign gpr_we    = RegWrite && gpr_space;
  assign gpr_idx   = WritetoRFaddr[4:0];
  assign hi_in     = WriteinRF_HI_LO_data[2*WIDTH-1:WIDTH];
  assign lo_in     = WriteinRF_HI_LO_data[WIDTH-1:0];

  // ------------------------------------------------------------------
  // GPR storage
  // ------------------------------------------------------------------
  // Reads are combinational with zero latency, so the file is built from
  // flops rather than a RAM with a registered read. Each register gets its
  // own write decode; entry 0 is hard-wired to zero and has no storage.
  logic [WIDTH-1:0] gpr_view [NUM_GPR];

  assign gpr_view[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_GPR; gi++) begin : g_gpr
      logic [WIDTH-1:0] value_reg;
      logic             hit;

      assign hit = gpr_we && (gpr_idx == 5'(gi));

      // Hold the register; reset dominates a coincident write.
      always_ff @(posedge clk) begin
        if (rst) begin
          value_reg <= '0;
        end else if (hit) begin
          value_reg <= WritetoRFdata;
        end
      end

      assign gpr_view[gi] = value_reg;
    end
  endgenerate

  // ------------------------------------------------------------------
  // HI / LO storage
  // ------------------------------------------------------------------
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;

  // HI/LO update is independent of the GPR write path.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_reg <= '0;
      lo_reg <= '0;
    end else if (HI_LO_writeenable) begin
      hi_reg <= hi_in;
      lo_reg <= lo_in;
    end
  end

  // ------------------------------------------------------------------
  // GPR read ports
  // ------------------------------------------------------------------
  // Ports are folded into arrays so both share one generated read path.
  logic [4:0]       raddr_arr [NUM_PORTS];
  logic [WIDTH-1:0] rdata_arr [NUM_PORTS];

  assign raddr_arr[0] = raddr1;
  assign raddr_arr[1] = raddr2;

  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_rport
      logic bypass_hit;

      assign bypass_hit = BYPASS && gpr_we && (gpr_idx == raddr_arr[gi]);

      // Priority: reset, $0, forwarded WB value, stored value. Reset returns
      // zero without forwarding because the incoming write will be dropped.
      always_comb begin
        rdata_arr[gi] = gpr_view[raddr_arr[gi]];
        if (rst) begin
          rdata_arr[gi] = '0;
        end else if (raddr_arr[gi] == 5'd0) begin
          rdata_arr[gi] = '0;
        end else if (bypass_hit) begin
          rdata_arr[gi] = WritetoRFdata;
        end
      end
    end
  endgenerate

  assign rdata1 = rdata_arr[0];
  assign rdata2 = rdata_arr[1];

  // ------------------------------------------------------------------
  // HI / LO read
  // ------------------------------------------------------------------
  // Forward the incoming halves when a HI/LO write is in flight.
  always_comb begin
    hi_out = hi_reg;
    lo_out = lo_reg;
    if (rst) begin
      hi_out = '0;
      lo_out = '0;
    end else if (BYPASS && HI_LO_writeenable) begin
      hi_out = hi_in;
      lo_out = lo_in;
    end
  end

  // ------------------------------------------------------------------
  // Commit trace
  // ------------------------------------------------------------------
  logic [31:0]      trace_pc_reg;
  logic [3:0]       trace_wen_reg;
  logic [4:0]       trace_wnum_reg;
  logic [WIDTH-1:0] trace_wdata_reg;

  // wen pulses for one cycle per GPR write (including $0 writes, which are
  // traced but not stored); pc/wnum/wdata keep the last committed write.
  always_ff @(posedge clk) begin
    if (rst) begin
      trace_wen_reg   <= 4'h0;
      trace_pc_reg    <= '0;
      trace_wnum_reg  <= '0;
      trace_wdata_reg <= '0;
    end else begin
      trace_wen_reg <= gpr_we ? 4'hF : 4'h0;
      if (gpr_we) begin
        trace_pc_reg    <= PC;
        trace_wnum_reg  <= gpr_idx;
        trace_wdata_reg <= WritetoRFdata;
      end
    end
  end

  assign debug_wb_pc       = trace_pc_reg;
  assign debug_wb_rf_wen   = trace_wen_reg;
  assign debug_wb_rf_wnum  = trace_wnum_reg;
  assign debug_wb_rf_wdata = trace_wdata_reg;

endmodule

// File: tb/tb_wb_regfile_hilo.sv
// tb_wb_regfile_hilo
// Directed stimulus pushes expected observations into a scoreboard tagged
// with the cycle they belong to; a negedge monitor pops and compares them.
module tb_wb_regfile_hilo;

  localparam int WIDTH = 32;

  localparam int SEL_RDATA1 = 0;
  localparam int SEL_RDATA2 = 1;
  localparam int SEL_HI     = 2;
  localparam int SEL_LO     = 3;
  localparam int SEL_WEN    = 4;
  localparam int SEL_WNUM   = 5;
  localparam int SEL_WDATA  = 6;
  localparam int SEL_PC     = 7;

  typedef struct {
    int          cyc;
    int          sel;
    logic [63:0] exp;
    string       name;
  } exp_t;

  logic               clk;
  logic               rst;
  logic               RegWrite;
  logic [6:0]         WritetoRFaddr;
  logic [WIDTH-1:0]   WritetoRFdata;
  logic               HI_LO_writeenable;
  logic [2*WIDTH-1:0] WriteinRF_HI_LO_data;
  logic [31:0]        PC;
  logic [4:0]         raddr1;
  logic [4:0]         raddr2;
  logic [WIDTH-1:0]   rdata1;
  logic [WIDTH-1:0]   rdata2;
  logic [WIDTH-1:0]   hi_out;
  logic [WIDTH-1:0]   lo_out;
  logic [31:0]        debug_wb_pc;
  logic [3:0]         debug_wb_rf_wen;
  logic [4:0]         debug_wb_rf_wnum;
  logic [WIDTH-1:0]   debug_wb_rf_wdata;

  wb_regfile_hilo #(.WIDTH(WIDTH), .BYPASS(1'b1)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .RegWrite             (RegWrite),
    .WritetoRFaddr        (WritetoRFaddr),
    .WritetoRFdata        (WritetoRFdata),
    .HI_LO_writeenable    (HI_LO_writeenable),
    .WriteinRF_HI_LO_data (WriteinRF_HI_LO_data),
    .PC                   (PC),
    .raddr1               (raddr1),
    .raddr2               (raddr2),
    .rdata1               (rdata1),
    .rdata2               (rdata2),
    .hi_out               (hi_out),
    .lo_out               (lo_out),
    .debug_wb_pc          (debug_wb_pc),
    .debug_wb_rf_wen      (debug_wb_rf_wen),
    .debug_wb_rf_wnum     (debug_wb_rf_wnum),
    .debug_wb_rf_wdata    (debug_wb_rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];
  bit   stim_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] observe(input int sel);
    case (sel)
      SEL_RDATA1: observe = 64'(rdata1);
      SEL_RDATA2: observe = 64'(rdata2);
      SEL_HI:     observe = 64'(hi_out);
      SEL_LO:     observe = 64'(lo_out);
      SEL_WEN:    observe = 64'(debug_wb_rf_wen);
      SEL_WNUM:   observe = 64'(debug_wb_rf_wnum);
      SEL_WDATA:  observe = 64'(debug_wb_rf_wdata);
      SEL_PC:     observe = 64'(debug_wb_pc);
      default:    observe = '1;
    endcase
  endfunction

  task automatic expect_now(input int sel, input logic [63:0] v, input string name);
    exp_t e;
    e.cyc = cyc; e.sel = sel; e.exp = v; e.name = name;
    sb.push_back(e);
  endtask

  // Monitor: compare every expectation that belongs to the current cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      logic [63:0] act;
      e = sb.pop_front();
      act = observe(e.sel);
      n_checks++;
      if (e.cyc != cyc) begin
        n_fail++;
        $display("FAIL %s: expectation for cycle %0d was skipped (now %0d)", e.name, e.cyc, cyc);
      end else if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: cycle %0d got 0x%0h, required 0x%0h", e.name, cyc, act, e.exp);
      end else begin
        $display("check %s: cycle %0d value 0x%0h ok", e.name, cyc, act);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gpr_write(input logic [6:0] a, input logic [31:0] d, input logic [31:0] pc);
    RegWrite = 1'b1; WritetoRFaddr = a; WritetoRFdata = d; PC = pc;
  endtask

  initial begin
    rst = 1'b1;
    HI_LO_writeenable = 1'b0;
    WriteinRF_HI_LO_data = '0;
    raddr1 = 5'd5; raddr2 = 5'd0;
    gpr_write(7'h05, 32'hDEAD_BEEF, 32'hBFC0_0000);
    tick();

    // Reset held two cycles with a write presented: dropped, reads zero.
    expect_now(SEL_RDATA1, 64'h0, "rst_rdata1_c1");
    expect_now(SEL_WEN,    64'h0, "rst_wen_c1");
    tick();
    expect_now(SEL_RDATA1, 64'h0, "rst_rdata1_c2");
    expect_now(SEL_WEN,    64'h0, "rst_wen_c2");
    tick();
    rst = 1'b0; RegWrite = 1'b0;
    expect_now(SEL_RDATA1, 64'h0, "post_rst_rdata1");
    expect_now(SEL_WEN,    64'h0, "post_rst_wen");
    expect_now(SEL_HI,     64'h0, "post_rst_hi");
    tick();
    expect_now(SEL_WEN,    64'h0, "post_rst_wen2");
    expect_now(SEL_RDATA1, 64'h0, "post_rst_r5");

    // Write r3 with same-cycle bypass, then trace and stored readback.
    gpr_write(7'h03, 32'h1234_5678, 32'hBFC0_0100);
    raddr2 = 5'd3;
    expect_now(SEL_RDATA2, 64'h1234_5678, "r3_bypass");
    tick();
    RegWrite = 1'b0;
    expect_now(SEL_WEN,    64'hF,           "r3_trace_wen");
    expect_now(SEL_WNUM,   64'd3,           "r3_trace_wnum");
    expect_now(SEL_WDATA,  64'h1234_5678,   "r3_trace_wdata");
    expect_now(SEL_PC,     64'hBFC0_0100,   "r3_trace_pc");
    expect_now(SEL_RDATA2, 64'h1234_5678,   "r3_stored");
    tick();
    expect_now(SEL_WEN,    64'h0, "r3_wen_drop");

    // $0 write: traced, never stored or forwarded.
    gpr_write(7'h00, 32'hFFFF_FFFF, 32'hBFC0_0104);
    raddr1 = 5'd0;
    expect_now(SEL_RDATA1, 64'h0, "r0_same_cycle");
    tick();
    RegWrite = 1'b0;
    expect_now(SEL_RDATA1, 64'h0,         "r0_after");
    expect_now(SEL_WEN,    64'hF,         "r0_trace_wen");
    expect_now(SEL_WNUM,   64'd0,         "r0_trace_wnum");
    expect_now(SEL_WDATA,  64'hFFFF_FFFF, "r0_trace_wdata");
    tick();

    // Preload r12, then a CP0-space write aliasing index 12 must be ignored.
    gpr_write(7'h0C, 32'h0000_0011, 32'hBFC0_0108);
    tick();
    RegWrite = 1'b0; raddr1 = 5'd12;
    expect_now(SEL_RDATA1, 64'h11, "r12_before");
    tick();
    gpr_write(7'h2C, 32'hAAAA_AAAA, 32'hBFC0_010C);
    expect_now(SEL_RDATA1, 64'h11, "cp0_no_bypass");
    expect_now(SEL_WEN,    64'h0,  "cp0_wen_prev");
    tick();
    RegWrite = 1'b0;
    expect_now(SEL_RDATA1, 64'h11,        "cp0_no_store");
    expect_now(SEL_WEN,    64'h0,         "cp0_no_trace");
    expect_now(SEL_WNUM,   64'd12,        "cp0_wnum_hold");
    expect_now(SEL_PC,     64'hBFC0_0108, "cp0_pc_hold");
    tick();

    // HI/LO write together with a GPR write to r31.
    HI_LO_writeenable = 1'b1;
    WriteinRF_HI_LO_data = 64'h0000_0001_FFFF_FFFE;
    gpr_write(7'h1F, 32'h8, 32'hBFC0_0110);
    raddr1 = 5'd31;
    expect_now(SEL_HI,     64'h1,         "hilo_bypass_hi");
    expect_now(SEL_LO,     64'hFFFF_FFFE, "hilo_bypass_lo");
    expect_now(SEL_RDATA1, 64'h8,         "r31_bypass");
    tick();
    HI_LO_writeenable = 1'b0; RegWrite = 1'b0;
    WriteinRF_HI_LO_data = 64'hDEAD_DEAD_DEAD_DEAD;
    expect_now(SEL_HI,     64'h1,         "hilo_stored_hi");
    expect_now(SEL_LO,     64'hFFFF_FFFE, "hilo_stored_lo");
    expect_now(SEL_RDATA1, 64'h8,         "r31_stored");
    expect_now(SEL_WNUM,   64'd31,        "r31_trace_wnum");
    tick();

    // Back-to-back writes to r4 with both ports reading r4.
    raddr1 = 5'd4; raddr2 = 5'd4;
    gpr_write(7'h04, 32'h1, 32'hBFC0_0114);
    expect_now(SEL_RDATA1, 64'h1, "b2b_n_p1");
    tick();
    gpr_write(7'h04, 32'h2, 32'hBFC0_0118);
    expect_now(SEL_RDATA1, 64'h2, "b2b_n1_p1");
    expect_now(SEL_RDATA2, 64'h2, "b2b_n1_p2");
    expect_now(SEL_WDATA,  64'h1, "b2b_trace_first");
    expect_now(SEL_WEN,    64'hF, "b2b_trace_wen1");
    tick();
    RegWrite = 1'b0;
    expect_now(SEL_RDATA1, 64'h2, "b2b_after_p1");
    expect_now(SEL_RDATA2, 64'h2, "b2b_after_p2");
    expect_now(SEL_WDATA,  64'h2, "b2b_trace_second");
    expect_now(SEL_WEN,    64'hF, "b2b_trace_wen2");
    tick();

    // Reset with writes presented: no bypass while asserted, all cleared.
    rst = 1'b1;
    gpr_write(7'h04, 32'h5, 32'hBFC0_011C);
    HI_LO_writeenable = 1'b1;
    WriteinRF_HI_LO_data = 64'h0000_0007_0000_0009;
    expect_now(SEL_RDATA1, 64'h0, "rst2_no_bypass");
    expect_now(SEL_HI,     64'h0, "rst2_hi_zero");
    tick();
    rst = 1'b0; RegWrite = 1'b0; HI_LO_writeenable = 1'b0;
    expect_now(SEL_RDATA1, 64'h0, "rst2_r4_cleared");
    expect_now(SEL_LO,     64'h0, "rst2_lo_cleared");
    expect_now(SEL_WEN,    64'h0, "rst2_wen");
    expect_now(SEL_PC,     64'h0, "rst2_pc");
    tick();
    tick();
    stim_done = 1'b1;
  end

  // Finish once the scoreboard drains, with a bounded wait.
  initial begin
    wait (stim_done);
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
